dbg_guv_ctl: RTL

- Multi-channel successor to the single-stream debug governor controller. Decodes the daisy-chained command stream and holds shadow and active control registers for NUM_CH governor channels.
- Drives per-channel pause/drop/log_en and inject streams into external axis_governor instances.
- Adds per-channel commit and status readback onto a backpressured response stream.

---
 rtl/dbg_guv_pkg.sv | 48 ++++
 rtl/dbg_guv_ch_regs.sv | 154 +++++++++++++++
 rtl/dbg_guv_ctl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_guv_pkg.sv
// Shared definitions for the multi-channel debug governor controller:
// register map, FSM encodings, address-flit field offsets, response bit positions.
package dbg_guv_pkg;

    localparam logic [3:0] REG_DROP_CNT      = 4'd0;
    localparam logic [3:0] REG_LOG_CNT       = 4'd1;
    localparam logic [3:0] REG_INJ_TDATA     = 4'd2;
    localparam logic [3:0] REG_INJ_TVALID    = 4'd3;
    localparam logic [3:0] REG_INJ_TLAST     = 4'd4;
    localparam logic [3:0] REG_INJ_TKEEP     = 4'd5;
    localparam logic [3:0] REG_INJ_TDEST     = 4'd6;
    localparam logic [3:0] REG_INJ_TID       = 4'd7;
    localparam logic [3:0] REG_KEEP_PAUSING  = 4'd8;
    localparam logic [3:0] REG_KEEP_LOGGING  = 4'd9;
    localparam logic [3:0] REG_KEEP_DROPPING = 4'd10;
    localparam logic [3:0] REG_READBACK      = 4'd14;
    localparam logic [3:0] REG_LATCH         = 4'd15;

    localparam logic [0:0] ST_ADDR = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;

    localparam int REG_LSB = 0;
    localparam int CH_LSB  = 4;

    function automatic int core_lsb(input int ch_w);
        return ch_w + 4;
    endfunction

    function automatic int core_msb(input int ch_w, input int addr_w);
        return addr_w + ch_w + 3;
    endfunction

    // Offsets inside the top status byte of a response flit
    localparam int RSP_KEEP_PAUSING  = 0;
    localparam int RSP_KEEP_LOGGING  = 1;
    localparam int RSP_KEEP_DROPPING = 2;
    localparam int RSP_INJ_TVALID    = 3;
    localparam int RSP_CH_LSB        = 4;

    function automatic int rsp_status_lsb(input int data_w);
        return data_w - 8;
    endfunction

    function automatic int rsp_overrun_bit(input int data_w);
        return data_w - 9;
    endfunction

endpackage

// File: rtl/dbg_guv_ch_regs.sv
// One governor channel: shadow registers written by the command decoder,
// active registers loaded on commit, and the saturating drop/log countdowns.
module dbg_guv_ch_regs
    import dbg_guv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 16,
    parameter int ID_WIDTH   = 16,
    parameter int CNT_SIZE   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en_i,
    input  logic [3:0]              wr_reg_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic                    commit_i,
    input  logic                    in_flit_i,
    input  logic                    log_flit_i,
    input  logic                    inj_tready_i,
    output logic                    pause_o,
    output logic                    drop_o,
    output logic                    log_en_o,
    output logic [DATA_WIDTH-1:0]   inj_tdata_o,
    output logic                    inj_tvalid_o,
    output logic [DATA_WIDTH/8-1:0] inj_tkeep_o,
    output logic [DEST_WIDTH-1:0]   inj_tdest_o,
    output logic [ID_WIDTH-1:0]     inj_tid_o,
    output logic                    inj_tlast_o,
    output logic [CNT_SIZE-1:0]     drop_cnt_o,
    output logic [CNT_SIZE-1:0]     log_cnt_o,
    output logic                    keep_pausing_o,
    output logic                    keep_logging_o,
    output logic                    keep_dropping_o
);

    logic [CNT_SIZE-1:0]     sh_drop_q, sh_log_q;
    logic [DATA_WIDTH-1:0]   sh_tdata_q;
    logic                    sh_tvalid_q, sh_tlast_q;
    logic [DATA_WIDTH/8-1:0] sh_tkeep_q;
    logic [DEST_WIDTH-1:0]   sh_tdest_q;
    logic [ID_WIDTH-1:0]     sh_tid_q;
    logic                    sh_kp_q, sh_kl_q, sh_kd_q;

    logic [CNT_SIZE-1:0]     drop_q, drop_d, log_q, log_d;
    logic                    tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0]   tdata_q;
    logic                    tlast_q;
    logic [DATA_WIDTH/8-1:0] tkeep_q;
    logic [DEST_WIDTH-1:0]   tdest_q;
    logic [ID_WIDTH-1:0]     tid_q;
    logic                    kp_q, kl_q, kd_q;

    logic unused_wr;
    assign unused_wr = ^wr_data_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_drop_q   <= '0;
            sh_log_q    <= '0;
            sh_tdata_q  <= '0;
            sh_tvalid_q <= 1'b0;
            sh_tlast_q  <= 1'b0;
            sh_tkeep_q  <= '0;
            sh_tdest_q  <= '0;
            sh_tid_q    <= '0;
            sh_kp_q     <= 1'b0;
            sh_kl_q     <= 1'b0;
            sh_kd_q     <= 1'b0;
        end else if (commit_i) begin
            // One-shot fields are consumed by a commit; inject payload is kept
            sh_drop_q   <= '0;
            sh_log_q    <= '0;
            sh_tvalid_q <= 1'b0;
            sh_kp_q     <= 1'b0;
            sh_kl_q     <= 1'b0;
            sh_kd_q     <= 1'b0;
        end else if (wr_en_i) begin
            case (wr_reg_i)
                REG_DROP_CNT:      sh_drop_q   <= wr_data_i[CNT_SIZE-1:0];
                REG_LOG_CNT:       sh_log_q    <= wr_data_i[CNT_SIZE-1:0];
                REG_INJ_TDATA:     sh_tdata_q  <= wr_data_i;
                REG_INJ_TVALID:    sh_tvalid_q <= wr_data_i[0];
                REG_INJ_TLAST:     sh_tlast_q  <= wr_data_i[0];
                REG_INJ_TKEEP:     sh_tkeep_q  <= wr_data_i[DATA_WIDTH/8-1:0];
                REG_INJ_TDEST:     sh_tdest_q  <= wr_data_i[DEST_WIDTH-1:0];
                REG_INJ_TID:       sh_tid_q    <= wr_data_i[ID_WIDTH-1:0];
                REG_KEEP_PAUSING:  sh_kp_q     <= wr_data_i[0];
                REG_KEEP_LOGGING:  sh_kl_q     <= wr_data_i[0];
                REG_KEEP_DROPPING: sh_kd_q     <= wr_data_i[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        drop_d   = drop_q;
        log_d    = log_q;
        tvalid_d = tvalid_q && !inj_tready_i;
        if (in_flit_i && drop_q != '0) drop_d = drop_q - CNT_SIZE'(1);
        if (log_flit_i && log_q != '0) log_d = log_q - CNT_SIZE'(1);
        // A commit overrides any same-cycle event on this channel
        if (commit_i) begin
            drop_d   = sh_drop_q;
            log_d    = sh_log_q;
            tvalid_d = sh_tvalid_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q   <= '0;
            log_q    <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tkeep_q  <= '0;
            tdest_q  <= '0;
            tid_q    <= '0;
            kp_q     <= 1'b0;
            kl_q     <= 1'b0;
            kd_q     <= 1'b0;
        end else begin
            drop_q   <= drop_d;
            log_q    <= log_d;
            tvalid_q <= tvalid_d;
            if (commit_i) begin
                tdata_q <= sh_tdata_q;
                tlast_q <= sh_tlast_q;
                tkeep_q <= sh_tkeep_q;
                tdest_q <= sh_tdest_q;
                tid_q   <= sh_tid_q;
                kp_q    <= sh_kp_q;
                kl_q    <= sh_kl_q;
                kd_q    <= sh_kd_q;
            end
        end
    end

    assign pause_o         = kp_q && drop_q == '0 && log_q == '0;
    assign log_en_o        = kl_q || log_q != '0;
    assign drop_o          = kd_q || drop_q != '0;
    assign inj_tdata_o     = tdata_q;
    assign inj_tvalid_o    = tvalid_q;
    assign inj_tkeep_o     = tkeep_q;
    assign inj_tdest_o     = tdest_q;
    assign inj_tid_o       = tid_q;
    assign inj_tlast_o     = tlast_q;
    assign drop_cnt_o      = drop_q;
    assign log_cnt_o       = log_q;
    assign keep_pausing_o  = kp_q;
    assign keep_logging_o  = kl_q;
    assign keep_dropping_o = kd_q;

endmodule

// File: rtl/dbg_guv_ctl.sv
// Multi-channel debug governor controller: command decode FSM, per-channel registers,
// daisy-chain forward and (with DBG_GUV_CTL_READBACK_EN) a one-entry status response buffer.
module dbg_guv_ctl
    import dbg_guv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 16,
    parameter int ID_WIDTH   = 16,
    parameter int CNT_SIZE   = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int ADDR       = 0,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int PIPE_STAGE = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH-1:0]              cmd_in_TDATA,
    input  logic                               cmd_in_TVALID,
    output logic [DATA_WIDTH-1:0]              cmd_out_TDATA,
    output logic                               cmd_out_TVALID,
    input  logic [NUM_CH-1:0]                  in_flit,
    input  logic [NUM_CH-1:0]                  log_flit,
    output logic [NUM_CH-1:0]                  pause,
    output logic [NUM_CH-1:0]                  drop,
    output logic [NUM_CH-1:0]                  log_en,
    output logic [NUM_CH*DATA_WIDTH-1:0]       inj_TDATA,
    output logic [NUM_CH-1:0]                  inj_TVALID,
    input  logic [NUM_CH-1:0]                  inj_TREADY,
    output logic [NUM_CH*(DATA_WIDTH/8)-1:0]   inj_TKEEP,
    output logic [NUM_CH*DEST_WIDTH-1:0]       inj_TDEST,
    output logic [NUM_CH*ID_WIDTH-1:0]         inj_TID,
    output logic [NUM_CH-1:0]                  inj_TLAST,
    output logic [DATA_WIDTH-1:0]              rsp_TDATA,
    output logic                               rsp_TVALID,
    input  logic                               rsp_TREADY
);

    localparam int CORE_LSB = core_lsb(CH_W);
    localparam int CORE_MSB = core_msb(CH_W, ADDR_WIDTH);

    logic [3:0]            a_reg;
    logic [CH_W-1:0]       a_ch;
    logic [ADDR_WIDTH-1:0] a_core;
    logic                  for_us;

    assign a_reg  = cmd_in_TDATA[REG_LSB +: 4];
    assign a_ch   = cmd_in_TDATA[CH_LSB +: CH_W];
    assign a_core = cmd_in_TDATA[CORE_MSB:CORE_LSB];
    assign for_us = cmd_in_TVALID && a_core == ADDR_WIDTH'(ADDR) && 32'(a_ch) < NUM_CH;

    logic [0:0]      state_q, state_d;
    logic [3:0]      reg_q, reg_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic            wr_en, commit_any, rb_req;

    always_comb begin
        state_d    = state_q;
        reg_d      = reg_q;
        ch_d       = ch_q;
        wr_en      = 1'b0;
        commit_any = 1'b0;
        rb_req     = 1'b0;
        case (state_q)
            ST_ADDR: begin
                if (for_us) begin
                    if (a_reg <= REG_KEEP_DROPPING) begin
                        state_d = ST_DATA;
                        reg_d   = a_reg;
                        ch_d    = a_ch;
                    end else if (a_reg == REG_LATCH) begin
                        commit_any = 1'b1;
                    end else if (a_reg == REG_READBACK) begin
                        rb_req = 1'b1;
                    end
                end
            end
            default: begin
                // Data flit is taken regardless of its core field
                if (cmd_in_TVALID) begin
                    wr_en   = 1'b1;
                    state_d = ST_ADDR;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ADDR;
            reg_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            ch_q    <= ch_d;
        end
    end

    logic [NUM_CH*CNT_SIZE-1:0] st_drop, st_log;
    logic [NUM_CH-1:0]          st_kp, st_kl, st_kd;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        dbg_guv_ch_regs #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEST_WIDTH (DEST_WIDTH),
            .ID_WIDTH   (ID_WIDTH),
            .CNT_SIZE   (CNT_SIZE)
        ) u_regs (
            .clk             (clk),
            .rst             (rst),
            .wr_en_i         (wr_en && ch_q == CH_W'(i)),
            .wr_reg_i        (reg_q),
            .wr_data_i       (cmd_in_TDATA),
            .commit_i        (commit_any && a_ch == CH_W'(i)),
            .in_flit_i       (in_flit[i]),
            .log_flit_i      (log_flit[i]),
            .inj_tready_i    (inj_TREADY[i]),
            .pause_o         (pause[i]),
            .drop_o          (drop[i]),
            .log_en_o        (log_en[i]),
            .inj_tdata_o     (inj_TDATA[i*DATA_WIDTH +: DATA_WIDTH]),
            .inj_tvalid_o    (inj_TVALID[i]),
            .inj_tkeep_o     (inj_TKEEP[i*(DATA_WIDTH/8) +: (DATA_WIDTH/8)]),
            .inj_tdest_o     (inj_TDEST[i*DEST_WIDTH +: DEST_WIDTH]),
            .inj_tid_o       (inj_TID[i*ID_WIDTH +: ID_WIDTH]),
            .inj_tlast_o     (inj_TLAST[i]),
            .drop_cnt_o      (st_drop[i*CNT_SIZE +: CNT_SIZE]),
            .log_cnt_o       (st_log[i*CNT_SIZE +: CNT_SIZE]),
            .keep_pausing_o  (st_kp[i]),
            .keep_logging_o  (st_kl[i]),
            .keep_dropping_o (st_kd[i])
        );
    end

`ifdef DBG_GUV_CTL_READBACK_EN
    localparam int ST_LSB = rsp_status_lsb(DATA_WIDTH);
    localparam int OVR_BIT = rsp_overrun_bit(DATA_WIDTH);

    logic                  rsp_valid_q, overrun_q, drain, accept;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [CNT_SIZE-1:0]   sel_drop, sel_log;
    logic                  sel_tvalid, sel_kp, sel_kl, sel_kd;

    assign drain  = rsp_valid_q && rsp_TREADY;
    assign accept = rb_req && (!rsp_valid_q || drain);

    always_comb begin
        sel_drop   = '0;
        sel_log    = '0;
        sel_tvalid = 1'b0;
        sel_kp     = 1'b0;
        sel_kl     = 1'b0;
        sel_kd     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (a_ch == CH_W'(i)) begin
                sel_drop   = st_drop[i*CNT_SIZE +: CNT_SIZE];
                sel_log    = st_log[i*CNT_SIZE +: CNT_SIZE];
                sel_tvalid = inj_TVALID[i];
                sel_kp     = st_kp[i];
                sel_kl     = st_kl[i];
                sel_kd     = st_kd[i];
            end
        end
        rsp_data_d = '0;
        rsp_data_d[CNT_SIZE-1:0] = sel_drop;
        for (int b = 0; b < CNT_SIZE; b++) begin
            if (CNT_SIZE + b < DATA_WIDTH) rsp_data_d[CNT_SIZE + b] = sel_log[b];
        end
        // Status byte and overrun flag take precedence over high log_cnt bits
        rsp_data_d[ST_LSB + RSP_CH_LSB +: 4]     = 4'(a_ch);
        rsp_data_d[ST_LSB + RSP_INJ_TVALID]      = sel_tvalid;
        rsp_data_d[ST_LSB + RSP_KEEP_DROPPING]   = sel_kd;
        rsp_data_d[ST_LSB + RSP_KEEP_LOGGING]    = sel_kl;
        rsp_data_d[ST_LSB + RSP_KEEP_PAUSING]    = sel_kp;
        rsp_data_d[OVR_BIT]                      = overrun_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rsp_data_d;
            overrun_q   <= 1'b0;
        end else begin
            if (drain) rsp_valid_q <= 1'b0;
            if (rb_req) overrun_q <= 1'b1;
        end
    end

    assign rsp_TVALID = rsp_valid_q;
    assign rsp_TDATA  = rsp_data_q;
`else
    logic unused_rsp;
    assign unused_rsp = ^{rsp_TREADY, rb_req, st_drop, st_log, st_kp, st_kl, st_kd};
    assign rsp_TVALID = 1'b0;
    assign rsp_TDATA  = '0;
`endif

    if (PIPE_STAGE != 0) begin : g_pipe
        logic [DATA_WIDTH-1:0] fwd_data_q;
        logic                  fwd_valid_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                fwd_data_q  <= '0;
                fwd_valid_q <= 1'b0;
            end else begin
                fwd_data_q  <= cmd_in_TDATA;
                fwd_valid_q <= cmd_in_TVALID;
            end
        end
        assign cmd_out_TDATA  = fwd_data_q;
        assign cmd_out_TVALID = fwd_valid_q;
    end else begin : g_comb
        assign cmd_out_TDATA  = cmd_in_TDATA;
        assign cmd_out_TVALID = cmd_in_TVALID;
    end

endmodule
